// File: rtl/bram_sdp_clr_if.sv
// Write/read/clear bus of the simple-dual-port frame-buffer RAM.
// Master drives requests; slave (the RAM) returns read data and sweep status.
interface bram_sdp_clr_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANE_WIDTH = 8
);
  localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  clear_start;
  logic                  clear_busy;
  logic                  we;
  logic [NUM_LANES-1:0]  wmask;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output clear_start, we, wmask, waddr, wdata, re, raddr,
    input  clear_busy, rdata, rvalid
  );

  modport slave (
    input  clear_start, we, wmask, waddr, wdata, re, raddr,
    output clear_busy, rdata, rvalid
  );
endinterface

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port block RAM with lane write mask, write-first collision bypass,
// 1/2-cycle read latency and a built-in sequential clear sweep.
module bram_sdp_clr #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LANE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset,
  bram_sdp_clr_if.slave   bus
);
  localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("bram_sdp_clr: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("bram_sdp_clr: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q;
  logic                  wr_acc_c, rd_acc_c;

  logic [NUM_LANES-1:0]  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [NUM_LANES-1:0]  hit_c;

  (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] mem_q;
  logic [NUM_LANES-1:0]  byp_mask_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] merged_c;

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= (state_d == CLEAR);
    end
  end

  // Next state and request acceptance
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_acc_c   = 1'b0;
    rd_acc_c   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_acc_c = bus.re;
        wr_acc_c = bus.we && !bus.clear_start;
        if (bus.clear_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      end
    endcase
  end

  // Single array write port shared by the sweep and user writes; reset blocks both
  always_comb begin
    mem_we_c    = '0;
    mem_waddr_c = bus.waddr;
    mem_wdata_c = bus.wdata;
    if (state_q == CLEAR) begin
      mem_we_c    = '1;
      mem_waddr_c = clr_addr_q;
      mem_wdata_c = CLEAR_VALUE;
    end else if (wr_acc_c) begin
      mem_we_c = bus.wmask;
    end
    if (reset) mem_we_c = '0;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (mem_we_c[i])
        mem[mem_waddr_c][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata_c[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign hit_c = (wr_acc_c && (bus.waddr == bus.raddr)) ? bus.wmask : '0;

  // Array read register plus captured collision lanes for the outside bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= rd_acc_c;
      if (rd_acc_c) begin
        mem_q      <= mem[bus.raddr];
        byp_mask_q <= hit_c;
        byp_data_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    merged_c = mem_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (byp_mask_q[i])
        merged_c[i*LANE_WIDTH +: LANE_WIDTH] = byp_data_q[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign bus.clear_busy = busy_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // Plain output register stage
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= v1_q;
        if (v1_q) rdata_q <= merged_c;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end else begin : g_lat1
    assign bus.rdata  = merged_c;
    assign bus.rvalid = v1_q;
  end
endmodule

// File: tb/tb_bram_sdp_clr.sv
// Directed self-checking bench: latency-1 instance for r/w, mask, collision,
// clear and reset-abort; latency-2 instance for pipelined reads.
module tb_bram_sdp_clr;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt;

  always #5 clk = ~clk;

  bram_sdp_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8)) ia ();
  bram_sdp_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8)) ib ();

  bram_sdp_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8),
    .READ_LATENCY(1), .CLEAR_VALUE(16'h0000)
  ) u_a (.clk(clk), .reset(reset), .bus(ia.slave));

  bram_sdp_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8),
    .READ_LATENCY(2), .CLEAR_VALUE(16'h0000)
  ) u_b (.clk(clk), .reset(reset), .bus(ib.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    ia.we = 1'b1; ia.waddr = a; ia.wdata = d; ia.wmask = m;
    tick();
    ia.we = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a, input logic [15:0] exp);
    ia.re = 1'b1; ia.raddr = a;
    tick();
    ia.re = 1'b0;
    check({tag, "_rvalid"}, 32'(ia.rvalid), 32'd1);
    check(tag, 32'(ia.rdata), 32'(exp));
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [15:0] d);
    ib.we = 1'b1; ib.waddr = a; ib.wdata = d; ib.wmask = 2'b11;
    tick();
    ib.we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ia.clear_start = 0; ia.we = 0; ia.wmask = 0; ia.waddr = 0; ia.wdata = 0; ia.re = 0; ia.raddr = 0;
    ib.clear_start = 0; ib.we = 0; ib.wmask = 0; ib.waddr = 0; ib.wdata = 0; ib.re = 0; ib.raddr = 0;
    repeat (3) tick();
    check("rst_busy", 32'(ia.clear_busy), 32'd0);
    check("rst_rvalid", 32'(ia.rvalid), 32'd0);
    check("rst_rdata", 32'(ia.rdata), 32'd0);
    check("rst_rvalid_l2", 32'(ib.rvalid), 32'd0);
    check("rst_rdata_l2", 32'(ib.rdata), 32'd0);
    reset = 1'b0;
    tick();

    // Basic write then read, output holds afterwards
    wr_a(4'd3, 16'h00A5, 2'b11);
    rd_a("basic", 4'd3, 16'h00A5);
    tick();
    check("basic_hold_rvalid", 32'(ia.rvalid), 32'd0);
    check("basic_hold_rdata", 32'(ia.rdata), 32'h00A5);

    // Lane mask, and an all-zero mask as a no-op
    wr_a(4'd5, 16'h1234, 2'b11);
    wr_a(4'd5, 16'hABCD, 2'b10);
    rd_a("mask", 4'd5, 16'hAB34);
    wr_a(4'd5, 16'hFFFF, 2'b00);
    rd_a("mask_zero", 4'd5, 16'hAB34);

    // Same-address collision is write-first per lane
    wr_a(4'd7, 16'h1111, 2'b11);
    ia.we = 1; ia.waddr = 4'd7; ia.wdata = 16'h2222; ia.wmask = 2'b01;
    ia.re = 1; ia.raddr = 4'd7;
    tick();
    ia.we = 0; ia.re = 0;
    check("coll_rvalid", 32'(ia.rvalid), 32'd1);
    check("coll", 32'(ia.rdata), 32'h1122);
    rd_a("coll_later", 4'd7, 16'h1122);

    // Clear sweep over a pre-filled array; read issued with clear_start is accepted
    for (int i = 0; i < 16; i++) wr_a(4'(i), 16'hFFFF, 2'b11);
    ia.clear_start = 1; ia.re = 1; ia.raddr = 4'd3;
    tick();
    ia.clear_start = 0;
    check("clr_busy_rise", 32'(ia.clear_busy), 32'd1);
    check("clr_start_rd_rvalid", 32'(ia.rvalid), 32'd1);
    check("clr_start_rd", 32'(ia.rdata), 32'hFFFF);
    ia.we = 1; ia.waddr = 4'd2; ia.wdata = 16'h1234; ia.wmask = 2'b11;
    ia.re = 1; ia.raddr = 4'd2;
    cnt = 0;
    while (ia.clear_busy && cnt < 40) begin
      cnt++;
      tick();
      check("clr_busy_rvalid", 32'(ia.rvalid), 32'd0);
    end
    check("clr_busy_len", 32'(cnt), 32'd16);
    check("clr_rdata_hold", 32'(ia.rdata), 32'hFFFF);
    // First cycle with busy low accepts both the write and the read
    tick();
    ia.we = 0; ia.re = 0;
    check("first_idle_rvalid", 32'(ia.rvalid), 32'd1);
    check("first_idle_wr", 32'(ia.rdata), 32'h1234);
    for (int i = 0; i < 16; i++)
      rd_a($sformatf("clr_a%0d", i), 4'(i), (i == 2) ? 16'h1234 : 16'h0000);

    // Reset on the sixth busy cycle aborts the sweep after address 4
    for (int i = 0; i < 16; i++) wr_a(4'(i), 16'hFFFF, 2'b11);
    ia.clear_start = 1; ia.re = 1; ia.raddr = 4'd9;
    tick();
    ia.clear_start = 0; ia.re = 0;
    check("abort_pre_rdata", 32'(ia.rdata), 32'hFFFF);
    repeat (5) tick();
    check("abort_busy_before", 32'(ia.clear_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(ia.clear_busy), 32'd0);
    check("abort_rvalid", 32'(ia.rvalid), 32'd0);
    check("abort_rdata", 32'(ia.rdata), 32'd0);
    for (int i = 0; i < 16; i++)
      rd_a($sformatf("abort_a%0d", i), 4'(i), (i < 5) ? 16'h0000 : 16'hFFFF);

    // Latency-2 pipelined reads with a write to a just-read address
    wr_b(4'd0, 16'h00AA);
    wr_b(4'd1, 16'h00BB);
    wr_b(4'd2, 16'h00CC);
    ib.re = 1; ib.raddr = 4'd0;
    tick();
    check("l2_gap", 32'(ib.rvalid), 32'd0);
    ib.raddr = 4'd1;
    tick();
    check("l2_v0", 32'(ib.rvalid), 32'd1);
    check("l2_d0", 32'(ib.rdata), 32'h00AA);
    ib.raddr = 4'd2;
    ib.we = 1; ib.waddr = 4'd1; ib.wdata = 16'h5555; ib.wmask = 2'b11;
    tick();
    ib.re = 0; ib.we = 0;
    check("l2_v1", 32'(ib.rvalid), 32'd1);
    check("l2_d1", 32'(ib.rdata), 32'h00BB);
    tick();
    check("l2_v2", 32'(ib.rvalid), 32'd1);
    check("l2_d2", 32'(ib.rdata), 32'h00CC);
    tick();
    check("l2_end_rvalid", 32'(ib.rvalid), 32'd0);
    check("l2_hold", 32'(ib.rdata), 32'h00CC);
    ib.re = 1; ib.raddr = 4'd1;
    tick();
    ib.re = 0;
    tick();
    check("l2_wr_seen_rvalid", 32'(ib.rvalid), 32'd1);
    check("l2_wr_seen", 32'(ib.rdata), 32'h5555);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
